pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the multicycle CPU. It holds the architectural PC and computes the next PC from five modes: sequential, branch, jump, register jump and return. It also captures an exception PC and keeps a small return-address stack (RAS) whose top is exported as a return-target prediction. It sits between the control unit (mode, write enable) and instruction memory (PC), and drives ALU/register-file links from `pc_plus4`.

## Interface
- `WIDTH`, 32: PC / data width; ≥ 30.
- `RESET_VEC`, 0: PC value after reset.
- `EXC_VEC`, 32'h0000_0080 (truncated to WIDTH): exception entry address.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥ 2.

- `clk`  in  1  clock; all state changes on the falling edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_we`  in  1  PC write enable (PCWre); low holds PC and RAS.
- `npc_op`  in  3  next-PC mode: 0 SEQ, 1 BR, 2 J, 3 JR, 4 RET, 5–7 treated as SEQ.
- `br_off`  in  WIDTH  sign-extended word offset for BR.
- `jtarget`  in  26  jump index for J.
- `rs_val`  in  WIDTH  register value for JR/RET.
- `ras_push`  in  1  push `pc_plus4` (call/jal); honoured only with `pc_we`.
- `exc`  in  1  exception request.
- `eret`  in  1  exception return.
- `pc`  out  WIDTH  current PC.
- `pc_plus4`  out  WIDTH  combinational `pc + 4`.
- `epc`  out  WIDTH  exception PC register.
- `ras_top`  out  WIDTH  predicted return target; 0 when empty.
- `ras_empty`, `ras_full`  out  1  RAS occupancy flags.
- `ras_ovf`, `ras_unf`  out  1  sticky overflow / underflow flags.
- `ras_miss`  out  1  one-cycle pulse: last RET prediction ≠ `rs_val`.

## Operation
- Reset (async, any time, including mid-operation) forces:
  - `pc = RESET_VEC`, `epc = 0`.
  - RAS count 0, `ras_empty = 1`, `ras_full = 0`.
  - `ras_ovf = ras_unf = ras_miss = 0`.
- Next-PC modes; all arithmetic is modulo 2^WIDTH and wraps silently:
  - SEQ: `pc + 4`.
  - BR: `pc + 4 + (br_off << 2)`.
  - J: `{pc_plus4[WIDTH-1:28], jtarget, 2'b00}`.
  - JR and RET: `rs_val`. RET is always architecturally correct; the RAS only predicts.
- Priority per falling edge: `exc` > `eret` > `pc_we`.
  - `exc`: `epc <= pc`, `pc <= EXC_VEC`. Ignores `pc_we`; RAS untouched.
  - `eret` (no `exc`): `pc <= epc`; RAS untouched.
  - `pc_we` with neither: `pc <=` next PC and RAS ops below apply.
  - `pc_we` low with neither: everything holds.
- RAS is a circular buffer with a top pointer and a count saturating at `RAS_DEPTH`.
  - Push: write `pc_plus4` at top+1. If full, the oldest entry is overwritten, count stays at `RAS_DEPTH`, and `ras_ovf` is set.
  - Pop (`npc_op == RET`):
    - If non-empty: compare top with `rs_val`, then decrement. On mismatch, `ras_miss` pulses.
    - If empty: `ras_unf` is set and no `ras_miss` pulse occurs.
  - Push and pop together: the top entry is replaced by `pc_plus4`, count is unchanged, and the compare still uses the old top.
  - `ras_ovf` and `ras_unf` clear only on reset.

## Timing
- `pc`, `epc` and RAS state update on the falling edge.
- `pc_plus4`, `ras_top`, `ras_empty` and `ras_full` are combinational from registered state.
- Latency: mode and operands are sampled at the falling edge; the new `pc` is visible immediately after it.
- `ras_miss` is registered. It is high for exactly one clock (falling edge to falling edge) after the pop edge and is cleared by the next edge unless another mismatch pop occurs.
- `exc` and `eret` are level-sampled. Held high for N edges, they act N times: repeated `exc` sets `epc` to `EXC_VEC` from the second edge on.

## Test plan
- Reset, then SEQ with `pc_we = 1` for 3 edges -> `pc` = 0, 4, 8, 12. Drop `pc_we` -> `pc` holds at 12; assert `rst` mid-cycle -> `pc = 0` immediately.
- BR at `pc = 0x100` with `br_off = -2` -> `pc = 0xFC`. J with `jtarget = 0x0000040` at `pc = 0x1000_0000` -> `pc = 0x1000_0100`. `pc = 0xFFFF_FFFC` with SEQ -> `pc = 0`.
- `exc` at `pc = 0x200` with `pc_we = 0` -> `pc = 0x80`, `epc = 0x200`. `exc` and `eret` together -> exception wins. Then `eret` -> `pc = 0x200`.
- Push 5 times (`RAS_DEPTH = 4`) from `pc` = 0x0, 0x4, 0x8, 0xC, 0x10 -> `ras_full = 1`, `ras_ovf = 1`, `ras_top = 0x14`. Then 4 RETs with matching `rs_val` -> no `ras_miss`, `ras_empty = 1`. A fifth RET -> `ras_unf = 1`, `pc = rs_val`.
- RET with `ras_top = 0x14` and `rs_val = 0x40` -> `pc = 0x40` and `ras_miss` high for exactly one cycle.
- Simultaneous push and RET with 2 entries -> count stays 2 and the top becomes the new `pc_plus4`.

Source files
------------

// File: rtl/pc_unit_if.sv
// Control/datapath bundle for the program-counter unit: mode inputs from the
// control unit and PC / return-stack outputs toward fetch and the datapath.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             pc_we;
    logic [2:0]       npc_op;
    logic [WIDTH-1:0] br_off;
    logic [25:0]      jtarget;
    logic [WIDTH-1:0] rs_val;
    logic             ras_push;
    logic             exc;
    logic             eret;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_ovf;
    logic             ras_unf;
    logic             ras_miss;

    modport master (
        output pc_we, npc_op, br_off, jtarget, rs_val, ras_push, exc, eret,
        input  pc, pc_plus4, epc, ras_top, ras_empty, ras_full,
               ras_ovf, ras_unf, ras_miss
    );

    modport slave (
        input  pc_we, npc_op, br_off, jtarget, rs_val, ras_push, exc, eret,
        output pc, pc_plus4, epc, ras_top, ras_empty, ras_full,
               ras_ovf, ras_unf, ras_miss
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with five next-PC modes, exception PC capture and a
// circular return-address stack used as a return-target predictor.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0080),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    pc_unit_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'd0,
        NPC_BR  = 3'd1,
        NPC_J   = 3'd2,
        NPC_JR  = 3'd3,
        NPC_RET = 3'd4
    } npc_op_t;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             unf_q;
    logic             miss_q;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] npc;
    logic [WIDTH-1:0] top_val;
    logic             empty;
    logic             full;
    logic             advance;
    logic             push;
    logic             pop;

    logic [PTR_W-1:0] top_n;
    logic [CNT_W-1:0] cnt_n;
    logic             ovf_n;
    logic             unf_n;
    logic             miss_n;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top_val  = ras_mem[top_q];

    // Exception and eret take the edge; only an ordinary advance touches the RAS.
    assign advance = bus.pc_we & ~bus.exc & ~bus.eret;
    assign push    = advance & bus.ras_push;
    assign pop     = advance & (bus.npc_op == NPC_RET);

    always_comb begin
        npc = pc_plus4;
        case (bus.npc_op)
            NPC_BR:          npc = pc_plus4 + (bus.br_off << 2);
            NPC_J:           npc = {pc_plus4[WIDTH-1:28], bus.jtarget, 2'b00};
            NPC_JR, NPC_RET: npc = bus.rs_val;
            default:         npc = pc_plus4;
        endcase
    end

    always_comb begin
        top_n  = top_q;
        cnt_n  = cnt_q;
        ovf_n  = ovf_q;
        unf_n  = unf_q;
        miss_n = 1'b0;
        wr_en  = 1'b0;
        wr_idx = top_q;

        if (pop && empty)
            unf_n = 1'b1;
        if (pop && !empty)
            miss_n = (top_val != bus.rs_val);

        // A call-and-return on a non-empty stack swaps the top in place.
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_q;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = top_q + 1'b1;
            top_n  = top_q + 1'b1;
            if (full)
                ovf_n = 1'b1;
            else
                cnt_n = cnt_q + 1'b1;
        end else if (pop && !empty) begin
            top_n = top_q - 1'b1;
            cnt_n = cnt_q - 1'b1;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_VEC;
            epc_q  <= '0;
            top_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            if (bus.exc) begin
                epc_q <= pc_q;
                pc_q  <= EXC_VEC;
            end else if (bus.eret) begin
                pc_q <= epc_q;
            end else if (bus.pc_we) begin
                pc_q <= npc;
            end
            top_q  <= top_n;
            cnt_q  <= cnt_n;
            ovf_q  <= ovf_n;
            unf_q  <= unf_n;
            miss_q <= miss_n;
        end
    end

    always_ff @(negedge clk) begin
        if (wr_en && !rst)
            ras_mem[wr_idx] <= pc_plus4;
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.epc       = epc_q;
    assign bus.ras_top   = empty ? '0 : top_val;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
    assign bus.ras_miss  = miss_q;
endmodule
